// File: rtl/modexp_stream_adapter.sv
// Host-side adapter for the modular-exponentiation engine.
// Collects a narrow word frame (base, power, modulus; LS word first) into
// SIZE-bit operands, issues them on three independent AXI-stream channels,
// then returns the engine result to the host as a narrow word stream.

// One engine-facing channel: valid is raised on issue and holds until its own
// handshake, so the three channels can complete in any order.
module modexp_stream_adapter_chan (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tready,
  output logic tvalid,
  output logic pending
);

  // Valid register: set on issue, cleared by its own handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tvalid <= 1'b0;
    else if (load)            tvalid <= 1'b1;
    else if (tvalid && tready) tvalid <= 1'b0;
  end

  // Still outstanding after the current edge.
  assign pending = tvalid & ~tready;

endmodule

module modexp_stream_adapter #(
  parameter int SIZE = 128,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] s_word_tdata,
  input  logic            s_word_tvalid,
  output logic            s_word_tready,
  input  logic            s_word_tlast,
  output logic [SIZE-1:0] base_tdata,
  output logic            base_tvalid,
  input  logic            base_tready,
  output logic [SIZE-1:0] power_tdata,
  output logic            power_tvalid,
  input  logic            power_tready,
  output logic [SIZE-1:0] modulus_tdata,
  output logic            modulus_tvalid,
  input  logic            modulus_tready,
  input  logic [SIZE-1:0] res_tdata,
  input  logic            res_tvalid,
  output logic            res_tready,
  output logic [WORD-1:0] m_word_tdata,
  output logic            m_word_tvalid,
  input  logic            m_word_tready,
  output logic            m_word_tlast,
  output logic            frame_err
);

  localparam int WORDS  = SIZE / WORD;
  localparam int FWORDS = 3 * WORDS;
  localparam int CW     = (FWORDS > 1) ? $clog2(FWORDS) : 1;
  localparam int IW     = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(FWORDS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  localparam logic [2:0] LOAD     = 3'd0;
  localparam logic [2:0] DRAIN    = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;

  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          err_nxt;
  logic          issue_load;
  logic          wr_en;
  logic          cap;
  logic          acc;
  logic          mod_zero;
  logic          s_rdy;

  // Frame slots: [0..WORDS-1] base, then power, then modulus.
  logic [FWORDS-1:0][WORD-1:0] fr;
  logic [WORDS-1:0][WORD-1:0]  res_q;

  logic [2:0] ch_rdy, ch_vld, ch_pend;

  assign acc = s_word_tvalid & s_word_tready;

  assign base_tdata    = fr[WORDS-1:0];
  assign power_tdata   = fr[2*WORDS-1:WORDS];
  assign modulus_tdata = fr[FWORDS-1:2*WORDS];

  assign ch_rdy         = {modulus_tready, power_tready, base_tready};
  assign base_tvalid    = ch_vld[0];
  assign power_tvalid   = ch_vld[1];
  assign modulus_tvalid = ch_vld[2];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_chan
      modexp_stream_adapter_chan u_chan (
        .clk     (clk),
        .rst     (rst),
        .load    (issue_load),
        .tready  (ch_rdy[g]),
        .tvalid  (ch_vld[g]),
        .pending (ch_pend[g])
      );
    end
  endgenerate

  // Zero-modulus detect, including the final word currently on the bus.
  always_comb begin
    mod_zero = (s_word_tdata == '0);
    for (int i = 2 * WORDS; i < FWORDS - 1; i++)
      if (fr[i] != '0) mod_zero = 1'b0;
  end

  // Next-state, counter and framing-error decode.
  always_comb begin
    nxt        = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    err_nxt    = 1'b0;
    issue_load = 1'b0;
    wr_en      = 1'b0;
    cap        = 1'b0;
    case (state)
      LOAD: begin
        if (acc) begin
          wr_en = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (!s_word_tlast) begin
              err_nxt = 1'b1;
              nxt     = DRAIN;
            end else if (mod_zero) begin
              err_nxt = 1'b1;
            end else begin
              issue_load = 1'b1;
              nxt        = ISSUE;
            end
          end else if (s_word_tlast) begin
            err_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (acc && s_word_tlast) nxt = LOAD;
      end
      ISSUE: begin
        if (ch_pend == 3'b000) nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_tvalid) begin
          cap     = 1'b1;
          idx_nxt = '0;
          nxt     = SEND;
        end
      end
      SEND: begin
        if (m_word_tready) begin
          if (idx == IDX_LAST) nxt = LOAD;
          else                 idx_nxt = idx + 1'b1;
        end
      end
      default: nxt = LOAD;
    endcase
  end

  // Control registers; ready to the host is registered so it stays low in reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      idx       <= '0;
      s_rdy     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      s_rdy     <= (nxt == LOAD) || (nxt == DRAIN);
      frame_err <= err_nxt;
    end
  end

  // Operand slot capture; slots are never written outside LOAD, so engine data
  // stays stable while any channel is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       fr <= '0;
    else if (wr_en) fr[cnt] <= s_word_tdata;
  end

  // Result capture from the engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     res_q <= '0;
    else if (cap) res_q <= res_tdata;
  end

  assign s_word_tready = s_rdy;
  assign res_tready    = (state == WAIT_RES);
  assign m_word_tvalid = (state == SEND);
  assign m_word_tdata  = res_q[idx];
  assign m_word_tlast  = (state == SEND) && (idx == IDX_LAST);

endmodule

// File: tb/tb_modexp_stream_adapter.sv
// Directed bench for modexp_stream_adapter with a behavioural modexp engine
// and a scoreboard of expected host result words.
module tb_modexp_stream_adapter;

  localparam int SIZE  = 128;
  localparam int WORD  = 32;
  localparam int WORDS = SIZE / WORD;

  logic            clk;
  logic            rst;
  logic [WORD-1:0] s_word_tdata;
  logic            s_word_tvalid;
  logic            s_word_tready;
  logic            s_word_tlast;
  logic [SIZE-1:0] base_tdata, power_tdata, modulus_tdata;
  logic            base_tvalid, power_tvalid, modulus_tvalid;
  logic            base_tready, power_tready, modulus_tready;
  logic [SIZE-1:0] res_tdata;
  logic            res_tvalid;
  logic            res_tready;
  logic [WORD-1:0] m_word_tdata;
  logic            m_word_tvalid;
  logic            m_word_tready;
  logic            m_word_tlast;
  logic            frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int err_pulses = 0;
  logic [WORD-1:0] q[$];
  logic [SIZE-1:0] got_b, got_p, got_m;

  modexp_stream_adapter #(.SIZE(SIZE), .WORD(WORD)) dut (
    .clk(clk), .rst(rst),
    .s_word_tdata(s_word_tdata), .s_word_tvalid(s_word_tvalid),
    .s_word_tready(s_word_tready), .s_word_tlast(s_word_tlast),
    .base_tdata(base_tdata), .base_tvalid(base_tvalid), .base_tready(base_tready),
    .power_tdata(power_tdata), .power_tvalid(power_tvalid), .power_tready(power_tready),
    .modulus_tdata(modulus_tdata), .modulus_tvalid(modulus_tvalid),
    .modulus_tready(modulus_tready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
    .m_word_tdata(m_word_tdata), .m_word_tvalid(m_word_tvalid),
    .m_word_tready(m_word_tready), .m_word_tlast(m_word_tlast),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count frame_err high cycles (one per pulse when pulses are single-cycle).
  always @(posedge clk) if (frame_err === 1'b1) err_pulses <= err_pulses + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [SIZE-1:0] modexp(input logic [SIZE-1:0] b, e, m);
    logic [2*SIZE-1:0] r, x, mm;
    mm = {{SIZE{1'b0}}, m};
    r  = 1 % mm;
    x  = {{SIZE{1'b0}}, b} % mm;
    for (int i = 0; i < SIZE; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[SIZE-1:0];
  endfunction

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nwords frame words from {m,p,b}; tlast on index last_at.
  task automatic send_words(input logic [SIZE-1:0] b, p, m, input int nwords, input int last_at);
    logic [3*SIZE-1:0] ops;
    int n;
    ops = {m, p, b};
    for (int i = 0; i < nwords; i++) begin
      s_word_tvalid = 1'b1;
      s_word_tdata  = ops[(i % (3 * WORDS)) * WORD +: WORD];
      s_word_tlast  = (i == last_at);
      n = 0;
      while (!s_word_tready && n < 50) begin tick(); n++; end
      if (n == 50) chk("s_ready_timeout", 0, 1);
      tick();
    end
    s_word_tvalid = 1'b0;
    s_word_tlast  = 1'b0;
  endtask

  // Engine side: channel readies open at cycle offsets db/dp/dm from first valid.
  task automatic engine_take(input logic [SIZE-1:0] b, p, m, input int db, dp, dm);
    bit tb, tp, tm;
    int k;
    tb = 0; tp = 0; tm = 0; k = 0;
    while (!(tb && tp && tm) && k < 40) begin
      base_tready    = !tb && (k >= db);
      power_tready   = !tp && (k >= dp);
      modulus_tready = !tm && (k >= dm);
      if (base_tready && base_tvalid)       begin got_b = base_tdata;    tb = 1; end
      if (power_tready && power_tvalid)     begin got_p = power_tdata;   tp = 1; end
      if (modulus_tready && modulus_tvalid) begin got_m = modulus_tdata; tm = 1; end
      tick();
      chk("base_vld",  base_tvalid,    !tb);
      chk("power_vld", power_tvalid,   !tp);
      chk("mod_vld",   modulus_tvalid, !tm);
      chk("res_rdy",   res_tready,     tb && tp && tm);
      k++;
    end
    base_tready = 1'b0; power_tready = 1'b0; modulus_tready = 1'b0;
    if (!(tb && tp && tm)) chk("engine_timeout", 0, 1);
    chk("eng_base", got_b, b);
    chk("eng_power", got_p, p);
    chk("eng_mod", got_m, m);
  endtask

  task automatic engine_result();
    chk("res_rdy_pre", res_tready, 1);
    res_tvalid = 1'b1;
    res_tdata  = modexp(got_b, got_p, got_m);
    tick();
    res_tvalid = 1'b0;
    chk("send_lat", m_word_tvalid, 1);
    chk("res_rdy_post", res_tready, 0);
  endtask

  // Host side: pat[c] is m_word_tready in SEND cycle c (c<4), then 1.
  task automatic recv(input logic [3:0] pat);
    int got, cyc;
    logic [WORD-1:0] held, exp;
    bit stalled;
    got = 0; cyc = 0; stalled = 0; held = '0;
    while (got < WORDS && cyc < 40) begin
      m_word_tready = (cyc < 4) ? pat[cyc] : 1'b1;
      if (stalled) chk("stall_hold", m_word_tdata, held);
      if (m_word_tvalid && m_word_tready) begin
        if (q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          exp = q.pop_front();
          chk("res_word", m_word_tdata, exp);
          chk("res_tlast", m_word_tlast, got == WORDS - 1);
        end
        got++;
        stalled = 0;
      end else if (m_word_tvalid) begin
        held = m_word_tdata;
        stalled = 1;
      end
      tick();
      cyc++;
    end
    if (got < WORDS) chk("recv_timeout", got, WORDS);
    chk("send_done", m_word_tvalid, 0);
    chk("load_rdy", s_word_tready, 1);
    tick();
    chk("no_extra", m_word_tvalid, 0);
    m_word_tready = 1'b0;
  endtask

  task automatic push_exp(input logic [SIZE-1:0] b, p, m);
    logic [SIZE-1:0] r;
    r = modexp(b, p, m);
    for (int i = 0; i < WORDS; i++) q.push_back(r[i * WORD +: WORD]);
  endtask

  task automatic run_frame(input logic [SIZE-1:0] b, p, m, input int db, dp, dm,
                           input logic [3:0] pat);
    push_exp(b, p, m);
    send_words(b, p, m, 3 * WORDS, 3 * WORDS - 1);
    chk("issue_lat", {base_tvalid, power_tvalid, modulus_tvalid}, 3'b111);
    chk("issue_nrdy", s_word_tready, 0);
    engine_take(b, p, m, db, dp, dm);
    engine_result();
    recv(pat);
  endtask

  task automatic check_idle_after_err(input string tag, input int e0);
    tick();
    chk({tag, "_err"}, err_pulses, e0 + 1);
    chk({tag, "_novld"}, {base_tvalid, power_tvalid, modulus_tvalid}, 3'b000);
    chk({tag, "_rdy"}, s_word_tready, 1);
  endtask

  initial begin
    int e0;
    logic [SIZE-1:0] mb;
    rst = 1'b0;
    s_word_tdata = '0; s_word_tvalid = 1'b0; s_word_tlast = 1'b0;
    base_tready = 1'b0; power_tready = 1'b0; modulus_tready = 1'b0;
    res_tdata = '0; res_tvalid = 1'b0; m_word_tready = 1'b0;
    mb = 128'hF000_0000_0000_0000_0000_0000_0000_0061;

    tick(); tick();
    chk("rst_s_rdy", s_word_tready, 0);
    chk("rst_valids", {base_tvalid, power_tvalid, modulus_tvalid, m_word_tvalid}, 4'b0000);
    chk("rst_res_rdy", res_tready, 0);
    chk("rst_tlast_err", {m_word_tlast, frame_err}, 2'b00);
    #2 rst = 1'b1;
    tick();
    chk("rel_s_rdy", s_word_tready, 1);

    // 1: basic 3^5 mod 7
    e0 = err_pulses;
    run_frame(128'd3, 128'd5, 128'd7, 0, 0, 0, 4'b1111);
    chk("t1_noerr", err_pulses, e0);

    // 2: staggered engine readies
    run_frame(128'h1234_5678_9abc_def0_0102, 128'h11, mb, 0, 5, 2, 4'b1111);

    // 3a: early tlast then recovery
    e0 = err_pulses;
    send_words(128'd3, 128'd5, 128'd7, 6, 5);
    check_idle_after_err("early", e0);
    run_frame(128'd10, 128'd3, 128'd13, 1, 1, 1, 4'b1111);

    // 3b: 13-word frame, drain through tlast, then recovery
    e0 = err_pulses;
    send_words(128'd4, 128'd6, 128'd9, 13, 12);
    check_idle_after_err("long", e0);
    run_frame(128'd2, 128'd10, 128'd1000, 0, 0, 0, 4'b1111);

    // 4: zero modulus
    e0 = err_pulses;
    send_words(128'd4, 128'd6, 128'd0, 12, 11);
    check_idle_after_err("modz", e0);

    // 5: host stalls during SEND
    run_frame(128'hDEAD_BEEF_0000_0001_CAFE, 128'h10001, mb, 0, 0, 0, 4'b1001);

    // 6a: reset during ISSUE
    send_words(128'd3, 128'd5, 128'd7, 12, 11);
    chk("r6a_issue", {base_tvalid, power_tvalid, modulus_tvalid}, 3'b111);
    #2 rst = 1'b0;
    #1;
    chk("r6a_valids", {base_tvalid, power_tvalid, modulus_tvalid}, 3'b000);
    chk("r6a_s_rdy", s_word_tready, 0);
    #2 rst = 1'b1;
    tick();
    run_frame(128'd7, 128'd3, 128'd11, 0, 0, 0, 4'b1111);

    // 6b: reset during SEND
    push_exp(128'd9, 128'd2, 128'd50);
    send_words(128'd9, 128'd2, 128'd50, 12, 11);
    engine_take(128'd9, 128'd2, 128'd50, 0, 0, 0);
    engine_result();
    tick();
    chk("r6b_send", m_word_tvalid, 1);
    #2 rst = 1'b0;
    #1;
    chk("r6b_valids", {m_word_tvalid, m_word_tlast, res_tready}, 3'b000);
    q.delete();
    #2 rst = 1'b1;
    tick();
    run_frame(128'd5, 128'd4, 128'd23, 2, 0, 1, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
